uart_pixel_packer: RTL and testbench
====================================

// Module: uart_pixel_packer
// PURPOSE
//  Packs the serial byte stream from the UART receiver into 24-bit RGB pixels.
//  Generates the BRAM port-A write address and write-enable, one pulse per pixel.
//  Sits between the UART byte receiver (100 MHz domain) and the dual-port frame BRAM.
//  The screen side reads the BRAM at 512x384, so one frame is 196608 pixels.
// PARAMETERS
//  NUM_PIXELS      196608     pixels per frame (512*384); write address wraps here
//  ADDR_W          18         width of pix_addr; must satisfy 2**ADDR_W >= NUM_PIXELS
//  TIMEOUT_CYCLES  1000000    idle cycles inside a partial pixel before it is discarded (10 ms @100 MHz)
//  TO_W            20         width of the gap counter; must satisfy 2**TO_W > TIMEOUT_CYCLES
// PORTS
//  clock       in   1       system clock, CLK100MHZ
//  reset       in   1       asynchronous, active-high reset
//  rx_data     in   8       received byte, valid only while rx_valid=1
//  rx_valid    in   1       one-cycle strobe per received byte
//  clear       in   1       synchronous frame restart: drops the partial pixel, address -> 0
//  pix_data    out  24      packed pixel {R,G,B} to BRAM dina
//  pix_we      out  1       one-cycle write strobe to BRAM wea
//  pix_addr    out  ADDR_W  BRAM addra; stable while pix_we=1
//  frame_done  out  1       one-cycle pulse, coincident with the pix_we of pixel NUM_PIXELS-1
//  resync      out  1       one-cycle pulse when a partial pixel is discarded by timeout
// BEHAVIOUR
//  Reset values
//   - pix_data=0, pix_we=0, pix_addr=0, frame_done=0, resync=0
//   - state=S_R, gap counter=0
//  FSM (state encoding in package)
//   - S_R: on rx_valid, capture byte into pix_data[23:16]; go to S_G.
//   - S_G: on rx_valid, capture byte into pix_data[15:8]; go to S_B.
//   - S_B: on rx_valid, capture byte into pix_data[7:0]; go to S_WR.
//   - S_WR (one cycle, ignores rx_valid): assert pix_we with the current pix_addr;
//     on the next edge pix_addr increments, then go to S_R.
//  Latency
//   - pix_we is high in the cycle after the clock edge that samples the third rx_valid.
//   - Each new byte is placed only in its own slice of pix_data; the slices filled
//     earlier keep their values.
//  Address wrap
//   - When pix_addr == NUM_PIXELS-1 during pix_we, assert frame_done in that same cycle.
//   - The next pix_addr is 0. pix_addr never takes a value >= NUM_PIXELS.
//  Gap timeout
//   - In S_G and S_B, the gap counter increments each cycle that rx_valid=0.
//   - rx_valid clears the counter.
//   - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid:
//     pulse resync, go to S_R, clear the counter, leave pix_addr unchanged, no pix_we.
//   - If rx_valid arrives in the same cycle the timeout would fire, the byte wins:
//     no resync, byte accepted.
//   - In S_R and S_WR the counter is held at 0.
//  clear
//   - Highest synchronous priority: state=S_R, pix_addr=0, counter=0.
//   - Any rx_valid in the same cycle is dropped.
//   - A pending S_WR write is cancelled: pix_we=0, frame_done=0.
//  Reset mid-frame
//   - Outputs go immediately to their reset values; the partial pixel is lost.
//  Guarantee
//   - pix_we never asserts twice within 4 cycles (minimum 3 bytes + 1 write cycle).
//   - The upstream UART byte rate is far slower than this, so no input buffering is needed.
// STRUCTURE
//  Package pixel_pkg
//   - typedef enum logic [1:0] {S_R, S_G, S_B, S_WR} pack_state_t
//   - localparams IMG_W=512, IMG_H=384, NUM_PIXELS=IMG_W*IMG_H, PIX_W=24
//   - Shared with the screen and filter blocks.
//  Sub-module byte_gap_timer
//   - Ports: clock, reset, run, kick, expired; parameters TIMEOUT_CYCLES, TO_W.
//   - The packer drives run=(state==S_G||state==S_B), kick=rx_valid|clear.
//  Top level: FSM, data slices, address counter, pulse outputs.
// TESTING
//  T1 bytes 0xAA,0x55,0x0F (gaps 868 cycles) -> one pix_we, pix_data=0xAA550F, pix_addr=0; next pixel at addr 1
//  T2 196608 pixels back-to-back, 4-cycle spacing -> frame_done only with addr 196607; following write at addr 0
//  T3 2 bytes, then silence for TIMEOUT_CYCLES -> resync pulse, no pix_we; next 3 bytes 0x11,0x22,0x33 write 0x112233 at unchanged addr
//  T4 rx_valid on exactly the timeout cycle -> no resync, byte accepted as G
//  T5 clear with rx_valid, mid-pixel and in S_WR -> no write, pix_addr=0; next full pixel writes at 0
//  T6 reset asserted asynchronously mid-pixel at addr 1000 -> all outputs 0 before the next edge; restart at addr 0

Source files
------------

// File: rtl/pixel_pkg.sv
// Frame geometry and packer state encoding shared by the packer, screen and filter blocks.
package pixel_pkg;

    typedef enum logic [1:0] {S_R, S_G, S_B, S_WR} pack_state_t;

    localparam int IMG_W      = 512;
    localparam int IMG_H      = 384;
    localparam int NUM_PIXELS = IMG_W * IMG_H;
    localparam int PIX_W      = 24;

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles while a partial pixel is open; flags when the gap has gone on too long.
module byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // A kick in the expiry cycle wins, so the pending byte is never lost.
    assign expired = run && !kick && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + TO_W'(1);
        if (!run || kick || expired) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART bytes R,G,B into 24-bit pixels and generates sequential BRAM write addresses.
module uart_pixel_packer #(
    parameter int NUM_PIXELS     = pixel_pkg::NUM_PIXELS,
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        clear,
    output logic [pixel_pkg::PIX_W-1:0] pix_data,
    output logic                        pix_we,
    output logic [ADDR_W-1:0]           pix_addr,
    output logic                        frame_done,
    output logic                        resync
);

    import pixel_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    pack_state_t        state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               we;
    logic               expired;

    byte_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_gap_timer (
        .clock   (clock),
        .reset   (reset),
        .run     ((state_q == S_G) || (state_q == S_B)),
        .kick    (rx_valid | clear),
        .expired (expired)
    );

    // rx_valid is a one-cycle strobe with no back-pressure: each strobe carries one
    // byte and is consumed in S_R/S_G/S_B; it is dropped in S_WR or alongside clear.
    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        addr_d  = addr_q;
        we      = 1'b0;
        if (clear) begin
            state_d = S_R;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_R: begin
                    if (rx_valid) begin
                        pix_d[23:16] = rx_data;
                        state_d      = S_G;
                    end
                end
                S_G: begin
                    if (rx_valid) begin
                        pix_d[15:8] = rx_data;
                        state_d     = S_B;
                    end else if (expired) begin
                        state_d = S_R;
                    end
                end
                S_B: begin
                    if (rx_valid) begin
                        pix_d[7:0] = rx_data;
                        state_d    = S_WR;
                    end else if (expired) begin
                        state_d = S_R;
                    end
                end
                S_WR: begin
                    we      = 1'b1;
                    state_d = S_R;
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                end
                default: state_d = S_R;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_R;
            pix_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            addr_q  <= addr_d;
        end
    end

    assign pix_data   = pix_q;
    assign pix_we     = we;
    assign pix_addr   = addr_q;
    assign frame_done = we && (addr_q == LAST_ADDR);
    assign resync     = expired;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Bench for uart_pixel_packer: directed and random byte streams against a byte-counting reference model.
module tb_uart_pixel_packer;

  localparam int NP = 48;
  localparam int AW = 6;
  localparam int TO = 40;
  localparam int TW = 6;

  logic          clock;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clear;
  logic [23:0]   pix_data;
  logic          pix_we;
  logic [AW-1:0] pix_addr;
  logic          frame_done;
  logic          resync;

  int vectors;
  int miscompares;

  // reference model: bytes collected, pending write, idle cycles since last byte
  int          m_nb;
  bit          m_wr;
  int          m_idle;
  int          m_addr;
  logic [23:0] m_pix;

  int cyc;
  int last_we_cyc;
  int spacing_err;

  uart_pixel_packer #(
    .NUM_PIXELS     (NP),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .clear      (clear),
    .pix_data   (pix_data),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .frame_done (frame_done),
    .resync     (resync)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (pix_we) begin
      if (last_we_cyc >= 0 && cyc - last_we_cyc < 4) spacing_err <= spacing_err + 1;
      last_we_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nb = 0; m_wr = 0; m_idle = 0; m_addr = 0; m_pix = '0;
  endtask

  // one clock cycle of stimulus, checked against the model
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    logic exp_we, exp_fd, exp_rs;
    rx_valid = v; rx_data = d; clear = c;
    #1;
    exp_we = m_wr && !c;
    exp_fd = exp_we && (m_addr == NP - 1);
    exp_rs = !c && !v && !m_wr && (m_nb > 0) && (m_idle + 1 == TO);
    chk("pix_we", {31'd0, pix_we}, {31'd0, exp_we});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    chk("resync", {31'd0, resync}, {31'd0, exp_rs});
    chk("pix_addr", 32'(pix_addr), 32'(m_addr));
    chk("pix_data", {8'd0, pix_data}, {8'd0, m_pix});
    if (c) begin
      m_nb = 0; m_wr = 0; m_idle = 0; m_addr = 0;
    end else if (m_wr) begin
      m_wr = 0;
      m_addr = (m_addr + 1) % NP;
    end else if (v) begin
      case (m_nb)
        0: m_pix[23:16] = d;
        1: m_pix[15:8]  = d;
        default: m_pix[7:0] = d;
      endcase
      m_idle = 0;
      m_nb++;
      if (m_nb == 3) begin
        m_nb = 0;
        m_wr = 1;
      end
    end else if (m_nb > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_nb = 0; m_idle = 0;
      end
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0; clear = 1'b0;
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    send(r); send(g); send(b); idle(1);
  endtask

  initial begin
    logic [7:0] b;
    vectors = 0; miscompares = 0;
    cyc = 0; last_we_cyc = -1; spacing_err = 0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; clear = 1'b0;
    model_reset();
    #2;
    chk("rst_we", {31'd0, pix_we}, 32'd0);
    chk("rst_addr", 32'(pix_addr), 32'd0);
    chk("rst_data", {8'd0, pix_data}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    chk("rst_resync", {31'd0, resync}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // T1: spaced bytes form one pixel at addr 0, next at addr 1
    send(8'hAA); idle(30); send(8'h55); idle(30); send(8'h0F); idle(3);
    pixel(8'h01, 8'h02, 8'h03); idle(2);

    // T2: back-to-back pixels across the address wrap
    for (int i = 0; i < 50; i++) pixel(8'(i), 8'(i + 1), 8'(i * 3));
    idle(2);

    // T3: partial pixel timed out, then a full pixel at the unchanged address
    send(8'hE1); send(8'hE2); idle(TO + 3);
    pixel(8'h11, 8'h22, 8'h33); idle(2);

    // T4: byte arriving on the expiry cycle wins, in both G and B slots
    send(8'h44); idle(TO - 1); send(8'h55); idle(TO - 1); send(8'h66); idle(2);

    // T5: clear with rx_valid mid-pixel, and clear during the write cycle
    send(8'h70); step(1'b1, 8'h77, 1'b1); idle(2);
    pixel(8'h80, 8'h81, 8'h82);
    send(8'h90); send(8'h91); step(1'b1, 8'h92, 1'b1); idle(2);
    send(8'hA0); send(8'hA1); send(8'hA2); step(1'b0, 8'h00, 1'b1); idle(2);
    pixel(8'hB0, 8'hB1, 8'hB2); idle(2);

    // random streams with gaps straddling the timeout
    for (int p = 0; p < 60; p++) begin
      idle($urandom_range(0, 6));
      for (int k = 0; k < 3; k++) begin
        b = 8'($urandom);
        if (k > 0) idle($urandom_range(0, TO + 8));
        send(b);
      end
      idle($urandom_range(1, 3));
    end

    // T6: asynchronous reset mid-pixel at addr 30
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 30; i++) pixel(8'hC0, 8'(i), 8'hC2);
    send(8'h9C); idle(1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_we", {31'd0, pix_we}, 32'd0);
    chk("arst_addr", 32'(pix_addr), 32'd0);
    chk("arst_data", {8'd0, pix_data}, 32'd0);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    chk("arst_resync", {31'd0, resync}, 32'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    pixel(8'hD1, 8'hD2, 8'hD3); idle(2);

    chk("we_spacing", 32'(spacing_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
